calc_seq_engine: RTL and testbench
==================================

# calc_seq_engine

Parametrised successor to the calculator controller/result-buffer pair. It walks a read address range of a dual-port memory in which each word holds two DATA_W operands, and applies a selectable operation (add, sub, max, min) to each operand pair. It packs two results into one memory word and writes them back over a write address range that wraps around. The block sits between the calculator top level and the two-SRAM memory, and adds a start/busy/done handshake and a sticky overflow flag.

## Interface
- DATA_W, 32, operand/result width; a memory word is 2*DATA_W
- ADDR_W, 9, memory address width
- clk_i  in  1  clock, all logic rising-edge
- rst_i  in  1  reset, asynchronous, active-low
- start_i  in  1  begin a job; sampled only in IDLE
- op_i  in  2  calc_op_e: 0 ADD, 1 SUB (a-b), 2 MAX, 3 MIN; latched at start
- read_start_addr / read_end_addr  in  ADDR_W  inclusive read range; latched at start
- write_start_addr / write_end_addr  in  ADDR_W  inclusive write range; latched at start
- rd_en_o  out  1  read request, active-high
- rd_addr_o  out  ADDR_W  read address
- rd_data_i  in  2*DATA_W  read data, valid exactly one cycle after rd_en_o; operand a = [DATA_W-1:0], operand b = upper half
- wr_en_o  out  1  write request, active-high
- wr_addr_o  out  ADDR_W  write address
- wr_data_o  out  2*DATA_W  write data
- busy_o  out  1  job in progress
- done_o  out  1  one-cycle pulse at job end
- ovf_o  out  1  sticky overflow flag; cleared on an accepted start

## Operation
- FSM states: IDLE, READ, CALC, WRITE, DONE.
- IDLE:
  - start_i=1 latches op, ranges and cur_rd=read_start, cur_wr=write_start, slot=0, buf=0, ovf=0.
  - If read_end<read_start, go to DONE with no memory access; otherwise go to READ.
  - start_i while not IDLE is ignored.
- READ: rd_en_o=1, rd_addr_o=cur_rd; go to CALC.
- CALC: compute result from rd_data_i and write it to buf[slot].
  - If slot==1 or cur_rd==read_end, go to WRITE.
  - Otherwise cur_rd++, slot=1, go to READ.
- WRITE: wr_en_o=1, wr_addr_o=cur_wr, wr_data_o=buf (slot0 in the low half).
  - If cur_rd==read_end, go to DONE.
  - Otherwise cur_rd++, slot=0, buf=0, and cur_wr advances; go to READ.
- Write address advance: cur_wr==write_end wraps to write_start, else cur_wr++.
  - If write_end<write_start, every write goes to write_start.
- Odd operand-pair count: the final word is written with the upper half zero.
- DONE: done_o=1 for one cycle, then IDLE.
- Arithmetic is unsigned, modulo 2^DATA_W:
  - ADD carry-out sets ovf.
  - SUB borrow (a<b) sets ovf.
  - MAX/MIN never set ovf.
- busy_o=1 in every state except IDLE.

## Timing
- Reset values: all outputs 0, state IDLE, internal registers 0.
- Reset asserted mid-job aborts immediately; no further rd_en_o/wr_en_o, and no done_o.
- All outputs are registered or decoded from state.
- rd_en_o and wr_en_o are never high in the same cycle.
- Accepted start to first rd_en_o: 1 cycle.
- Per written word: 5 cycles for a full pair (READ, CALC, READ, CALC, WRITE); 3 cycles for a final half word.
- done_o follows the last wr_en_o by 1 cycle.
- Job of N read words: busy_o for 2N + ceil(N/2) + 1 cycles.

## Configuration
- CALC_SAT_EN defined:
  - ADD clamps to all-ones on carry.
  - SUB clamps to 0 on borrow.
  - ovf_o is still set in both cases.
- CALC_SAT_EN undefined: results wrap modulo 2^DATA_W.

## Structure
- calculator_pkg holds:
  - calc_op_e
  - state enum calc_state_e
  - default DATA_W/ADDR_W constants
  - MEM_WORD_SIZE = 2*DATA_W
- One combinational sub-module, calc_alu (a, b, op → result, ovf), contains the CALC_SAT_EN logic.
- The FSM, address counters and pack buffer live in calc_seq_engine.

## Test plan
- ADD, read 0..1 = {b=2,a=1},{b=5,a=3}, write 16..16 → one write at 16 of {8,3}; done_o 1 cycle after it; ovf_o=0.
- ADD with a=0xFFFFFFFF, b=2 → low half 0x00000001 with ovf_o=1; with CALC_SAT_EN → 0xFFFFFFFF with ovf_o=1.
- SUB/MAX/MIN on a=7, b=9 → 0xFFFFFFFE (0 with CALC_SAT_EN) with ovf_o=1; MAX 9; MIN 7.
- Read 0..4 (5 words), write 20..21 → writes to 20, 21, 20; third word upper half 0.
- read_end<read_start → no rd_en_o/wr_en_o, done_o 1 cycle after start; start_i held during a job is ignored.
- rst_i low in cycle 3 of a job → all outputs 0 next edge, no write issued; a new start then runs normally.

Source files
------------

// File: rtl/calculator_pkg.sv
// Shared types and default widths for the calculator sequencing engine.
package calculator_pkg;

  localparam int unsigned DATA_W_DEFAULT = 32;
  localparam int unsigned ADDR_W_DEFAULT = 9;
  localparam int unsigned MEM_WORD_SIZE  = 2 * DATA_W_DEFAULT;

  typedef enum logic [1:0] {
    OpAdd = 2'd0,
    OpSub = 2'd1,
    OpMax = 2'd2,
    OpMin = 2'd3
  } calc_op_e;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StCalc,
    StWrite,
    StDone
  } calc_state_e;

endpackage

// File: rtl/calc_alu.sv
// Combinational operand-pair ALU: add, sub (a-b), max, min, all unsigned.
// Optional feature macro: CALC_SAT_EN (saturate ADD on carry, SUB on borrow).
module calc_alu
  import calculator_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  calc_op_e          op_i,
  output logic [DATA_W-1:0] result_o,
  output logic              ovf_o
);

  logic [DATA_W:0] sum;
  logic            borrow;

  assign sum    = {1'b0, a_i} + {1'b0, b_i};
  assign borrow = (a_i < b_i);

  // Select the result; ovf reports carry/borrow whether or not the result saturates.
  always_comb begin
    result_o = '0;
    ovf_o    = 1'b0;
    unique case (op_i)
      OpAdd: begin
        ovf_o = sum[DATA_W];
`ifdef CALC_SAT_EN
        result_o = sum[DATA_W] ? '1 : sum[DATA_W-1:0];
`else
        result_o = sum[DATA_W-1:0];
`endif
      end
      OpSub: begin
        ovf_o = borrow;
`ifdef CALC_SAT_EN
        result_o = borrow ? '0 : (a_i - b_i);
`else
        result_o = a_i - b_i;
`endif
      end
      OpMax:   result_o = (a_i > b_i) ? a_i : b_i;
      OpMin:   result_o = (a_i < b_i) ? a_i : b_i;
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/calc_seq_engine.sv
// Walks a read range, applies the ALU to each operand pair, packs two results
// per word and writes them over a wrapping write range.
// Optional feature macro: CALC_SAT_EN (handled inside calc_alu).
module calc_seq_engine
  import calculator_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [1:0]          op_i,
  input  logic [ADDR_W-1:0]   read_start_addr,
  input  logic [ADDR_W-1:0]   read_end_addr,
  input  logic [ADDR_W-1:0]   write_start_addr,
  input  logic [ADDR_W-1:0]   write_end_addr,
  output logic                rd_en_o,
  output logic [ADDR_W-1:0]   rd_addr_o,
  input  logic [2*DATA_W-1:0] rd_data_i,
  output logic                wr_en_o,
  output logic [ADDR_W-1:0]   wr_addr_o,
  output logic [2*DATA_W-1:0] wr_data_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                ovf_o
);

  localparam logic [ADDR_W-1:0] AddrOne = ADDR_W'(1);

  calc_state_e         state_q, state_d;
  calc_op_e            op_q, op_d;
  logic [ADDR_W-1:0]   rd_end_q, rd_end_d;
  logic [ADDR_W-1:0]   wr_start_q, wr_start_d;
  logic [ADDR_W-1:0]   wr_end_q, wr_end_d;
  logic [ADDR_W-1:0]   cur_rd_q, cur_rd_d;
  logic [ADDR_W-1:0]   cur_wr_q, cur_wr_d;
  logic                slot_q, slot_d;
  logic [2*DATA_W-1:0] buf_q, buf_d;
  logic                ovf_q, ovf_d;

  logic [DATA_W-1:0]   alu_result;
  logic                alu_ovf;

  calc_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .a_i      (rd_data_i[DATA_W-1:0]),
    .b_i      (rd_data_i[2*DATA_W-1:DATA_W]),
    .op_i     (op_q),
    .result_o (alu_result),
    .ovf_o    (alu_ovf)
  );

  // State and datapath registers; reset aborts any job in flight.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= StIdle;
      op_q       <= OpAdd;
      rd_end_q   <= '0;
      wr_start_q <= '0;
      wr_end_q   <= '0;
      cur_rd_q   <= '0;
      cur_wr_q   <= '0;
      slot_q     <= 1'b0;
      buf_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      rd_end_q   <= rd_end_d;
      wr_start_q <= wr_start_d;
      wr_end_q   <= wr_end_d;
      cur_rd_q   <= cur_rd_d;
      cur_wr_q   <= cur_wr_d;
      slot_q     <= slot_d;
      buf_q      <= buf_d;
      ovf_q      <= ovf_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    rd_end_d   = rd_end_q;
    wr_start_d = wr_start_q;
    wr_end_d   = wr_end_q;
    cur_rd_d   = cur_rd_q;
    cur_wr_d   = cur_wr_q;
    slot_d     = slot_q;
    buf_d      = buf_q;
    ovf_d      = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          op_d       = calc_op_e'(op_i);
          rd_end_d   = read_end_addr;
          wr_start_d = write_start_addr;
          wr_end_d   = write_end_addr;
          cur_rd_d   = read_start_addr;
          cur_wr_d   = write_start_addr;
          slot_d     = 1'b0;
          buf_d      = '0;
          ovf_d      = 1'b0;
          state_d    = (read_end_addr < read_start_addr) ? StDone : StRead;
        end
      end
      StRead: state_d = StCalc;
      StCalc: begin
        if (slot_q) buf_d[2*DATA_W-1:DATA_W] = alu_result;
        else        buf_d[DATA_W-1:0]        = alu_result;
        ovf_d = ovf_q | alu_ovf;
        if (slot_q || (cur_rd_q == rd_end_q)) begin
          state_d = StWrite;
        end else begin
          cur_rd_d = cur_rd_q + AddrOne;
          slot_d   = 1'b1;
          state_d  = StRead;
        end
      end
      StWrite: begin
        if (cur_rd_q == rd_end_q) begin
          state_d = StDone;
        end else begin
          cur_rd_d = cur_rd_q + AddrOne;
          slot_d   = 1'b0;
          buf_d    = '0;
          // An inverted write range pins every write to its start address.
          if ((wr_end_q < wr_start_q) || (cur_wr_q == wr_end_q)) cur_wr_d = wr_start_q;
          else                                                   cur_wr_d = cur_wr_q + AddrOne;
          state_d = StRead;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign rd_en_o   = (state_q == StRead);
  assign wr_en_o   = (state_q == StWrite);
  assign done_o    = (state_q == StDone);
  assign busy_o    = (state_q != StIdle);
  assign rd_addr_o = cur_rd_q;
  assign wr_addr_o = cur_wr_q;
  assign wr_data_o = buf_q;
  assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_calc_seq_engine.sv
// Directed bench for calc_seq_engine with a one-cycle-latency memory model.
module tb_calc_seq_engine;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 9;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          start_i;
  logic [1:0]    op_i;
  logic [AW-1:0] read_start_addr, read_end_addr, write_start_addr, write_end_addr;
  logic          rd_en_o, wr_en_o, busy_o, done_o, ovf_o;
  logic [AW-1:0] rd_addr_o, wr_addr_o;
  logic [2*DW-1:0] rd_data_i, wr_data_o;

  logic [2*DW-1:0] mem [0:(1<<AW)-1];

  int n_total = 0;
  int n_bad   = 0;

  // Job observation results.
  int busy_cnt, rd_cnt, both_cnt, done_cyc;
  logic [AW-1:0]   wa_q[$];
  logic [2*DW-1:0] wd_q[$];
  int              wc_q[$];

  calc_seq_engine #(
    .DATA_W (DW),
    .ADDR_W (AW)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .start_i          (start_i),
    .op_i             (op_i),
    .read_start_addr  (read_start_addr),
    .read_end_addr    (read_end_addr),
    .write_start_addr (write_start_addr),
    .write_end_addr   (write_end_addr),
    .rd_en_o          (rd_en_o),
    .rd_addr_o        (rd_addr_o),
    .rd_data_i        (rd_data_i),
    .wr_en_o          (wr_en_o),
    .wr_addr_o        (wr_addr_o),
    .wr_data_o        (wr_data_o),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .ovf_o            (ovf_o)
  );

  always #5 clk_i = ~clk_i;

  // Read data valid one cycle after the request.
  always @(posedge clk_i) if (rd_en_o) rd_data_i <= mem[rd_addr_o];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one job and observe it until done_o (bounded).
  task automatic run_job(input logic [1:0] op, input int rs, input int re, input int ws,
                         input int we, input bit hold);
    busy_cnt = 0; rd_cnt = 0; both_cnt = 0; done_cyc = 0;
    wa_q.delete(); wd_q.delete(); wc_q.delete();
    @(negedge clk_i);
    op_i = op;
    read_start_addr  = AW'(rs);
    read_end_addr    = AW'(re);
    write_start_addr = AW'(ws);
    write_end_addr   = AW'(we);
    start_i = 1'b1;
    @(negedge clk_i);
    if (!hold) start_i = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      if (c > 1) @(negedge clk_i);
      if (busy_o) busy_cnt++;
      if (rd_en_o) rd_cnt++;
      if (rd_en_o && wr_en_o) both_cnt++;
      if (wr_en_o) begin
        wa_q.push_back(wr_addr_o);
        wd_q.push_back(wr_data_o);
        wc_q.push_back(c);
      end
      if (done_o) begin
        done_cyc = c;
        break;
      end
    end
    start_i = 1'b0;
    if (done_cyc == 0) check_eq("job_timeout", 64'd1, 64'd0);
    @(negedge clk_i);
    check_eq("idle_after_done", {63'd0, busy_o}, 64'd0);
  endtask

  logic [63:0] exp_add_ovf, exp_sub;
  int          stray;

  initial begin
`ifdef CALC_SAT_EN
    exp_add_ovf = 64'h0000_0000_FFFF_FFFF;
    exp_sub     = 64'h0000_0000_0000_0000;
`else
    exp_add_ovf = 64'h0000_0000_0000_0001;
    exp_sub     = 64'h0000_0000_FFFF_FFFE;
`endif
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    mem[0]  = {32'd2, 32'd1};
    mem[1]  = {32'd5, 32'd3};
    mem[2]  = {32'd2, 32'hFFFF_FFFF};
    mem[3]  = {32'd9, 32'd7};
    mem[10] = {32'd1, 32'd10};
    mem[11] = {32'd2, 32'd20};
    mem[12] = {32'd3, 32'd30};
    mem[13] = {32'd4, 32'd40};
    mem[14] = {32'd5, 32'd50};
    rd_data_i = '0;
    rst_i = 1'b0; start_i = 1'b0; op_i = 2'd0;
    read_start_addr = '0; read_end_addr = '0; write_start_addr = '0; write_end_addr = '0;
    repeat (3) @(posedge clk_i);
    #1;
    check_eq("rst_outs", {rd_en_o, wr_en_o, busy_o, done_o, ovf_o}, 64'd0);
    check_eq("rst_addr", {rd_addr_o, wr_addr_o}, 64'd0);
    check_eq("rst_wdata", wr_data_o, 64'd0);
    @(negedge clk_i);
    rst_i = 1'b1;

    // ADD, two words into one write.
    run_job(2'd0, 0, 1, 16, 16, 1'b0);
    check_eq("add_nwr", wa_q.size(), 64'd1);
    if (wa_q.size() == 1) begin
      check_eq("add_waddr", wa_q[0], 64'd16);
      check_eq("add_wdata", wd_q[0], 64'h0000_0008_0000_0003);
      check_eq("add_done_lat", done_cyc - wc_q[0], 64'd1);
    end
    check_eq("add_ovf", ovf_o, 64'd0);
    check_eq("add_busy", busy_cnt, 64'd6);
    check_eq("add_first_rd", rd_cnt, 64'd2);

    // ADD with carry, single word.
    run_job(2'd0, 2, 2, 30, 30, 1'b0);
    if (wd_q.size() == 1) check_eq("addovf_wdata", wd_q[0], exp_add_ovf);
    else check_eq("addovf_nwr", wd_q.size(), 64'd1);
    check_eq("addovf_ovf", ovf_o, 64'd1);
    check_eq("addovf_busy", busy_cnt, 64'd4);

    // SUB with borrow, then MAX and MIN clear ovf at start.
    run_job(2'd1, 3, 3, 31, 31, 1'b0);
    if (wd_q.size() == 1) check_eq("sub_wdata", wd_q[0], exp_sub);
    check_eq("sub_ovf", ovf_o, 64'd1);
    run_job(2'd2, 3, 3, 31, 31, 1'b0);
    if (wd_q.size() == 1) check_eq("max_wdata", wd_q[0], 64'd9);
    check_eq("max_ovf", ovf_o, 64'd0);
    run_job(2'd3, 3, 3, 31, 31, 1'b0);
    if (wd_q.size() == 1) check_eq("min_wdata", wd_q[0], 64'd7);

    // Five words over a two-word wrapping write range.
    run_job(2'd0, 10, 14, 20, 21, 1'b0);
    check_eq("wrap_nwr", wa_q.size(), 64'd3);
    if (wa_q.size() == 3) begin
      check_eq("wrap_a0", wa_q[0], 64'd20);
      check_eq("wrap_d0", wd_q[0], {32'd22, 32'd11});
      check_eq("wrap_a1", wa_q[1], 64'd21);
      check_eq("wrap_d1", wd_q[1], {32'd44, 32'd33});
      check_eq("wrap_a2", wa_q[2], 64'd20);
      check_eq("wrap_d2", wd_q[2], {32'd0, 32'd55});
      check_eq("wrap_done_lat", done_cyc - wc_q[2], 64'd1);
    end
    check_eq("wrap_busy", busy_cnt, 64'd14);
    check_eq("wrap_nrd", rd_cnt, 64'd5);
    check_eq("wrap_excl", both_cnt, 64'd0);

    // Inverted write range: every write lands on write_start.
    run_job(2'd0, 10, 13, 40, 35, 1'b0);
    check_eq("inv_nwr", wa_q.size(), 64'd2);
    if (wa_q.size() == 2) begin
      check_eq("inv_a0", wa_q[0], 64'd40);
      check_eq("inv_a1", wa_q[1], 64'd40);
    end

    // Empty read range.
    run_job(2'd0, 5, 4, 16, 16, 1'b0);
    check_eq("empty_nrd", rd_cnt, 64'd0);
    check_eq("empty_nwr", wa_q.size(), 64'd0);
    check_eq("empty_done", done_cyc, 64'd1);
    check_eq("empty_busy", busy_cnt, 64'd1);

    // start_i held through a job has no effect until IDLE.
    run_job(2'd0, 0, 1, 16, 16, 1'b1);
    check_eq("hold_nwr", wa_q.size(), 64'd1);
    check_eq("hold_busy", busy_cnt, 64'd6);

    // Reset in cycle 3 of a job.
    @(negedge clk_i);
    op_i = 2'd0;
    read_start_addr = 9'd10; read_end_addr = 9'd14;
    write_start_addr = 9'd20; write_end_addr = 9'd21;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    check_eq("midrst_outs", {rd_en_o, wr_en_o, busy_o, done_o, ovf_o}, 64'd0);
    check_eq("midrst_addr", {rd_addr_o, wr_addr_o}, 64'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    stray = 0;
    repeat (12) begin
      @(negedge clk_i);
      if (rd_en_o || wr_en_o || done_o || busy_o) stray++;
    end
    check_eq("midrst_quiet", stray, 64'd0);
    run_job(2'd0, 0, 1, 16, 16, 1'b0);
    if (wd_q.size() == 1) check_eq("postrst_wdata", wd_q[0], 64'h0000_0008_0000_0003);
    else check_eq("postrst_nwr", wd_q.size(), 64'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
